// File: rtl/period_meter_pkg.sv
// Shared types and default constants for the period meter.
// Holds the FSM state encoding and the default counter width and timeout.
package period_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_TOUT    = 2'd2
    } state_t;

    localparam int CNT_W_DEF   = 32;
    localparam int TIMEOUT_DEF = 20000000;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus edge register for an asynchronous input.
// Ports: clk, rst (async, active-high), din in; level, rise, fall out.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~s3;
    assign fall  = ~s2 & s3;

endmodule

// File: rtl/period_meter.sv
// Measures rising-to-rising period (and optionally high time) of sig_in.
// Ports: clk, rst, sig_in in; period, period_vld, high_time, timeout out.
// Macro PERIOD_METER_HIGH_TIME_EN builds the high-time counter.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic             period_vld,
    output logic [CNT_W-1:0] high_time,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic             level;
    logic             rise;
    logic             fall;
    state_t           state;
    logic [CNT_W-1:0] cntr;

    sync_edge_det u_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (sig_in),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    // Falling edges carry no information for this block.
    logic unused_edge;
    assign unused_edge = ^{fall, level};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cntr       <= '0;
            period     <= '0;
            period_vld <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            period_vld <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (rise) begin
                        cntr  <= ONE;
                        state <= ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    // A rise wins over the timeout in the same cycle.
                    if (rise) begin
                        period     <= cntr;
                        period_vld <= 1'b1;
                        cntr       <= ONE;
                    end else if (cntr == TMO) begin
                        timeout <= 1'b1;
                        state   <= ST_TOUT;
                    end else begin
                        cntr <= cntr + ONE;
                    end
                end
                ST_TOUT: begin
                    // Stale interval: restart without a strobe.
                    if (rise) begin
                        timeout <= 1'b0;
                        cntr    <= ONE;
                        state   <= ST_MEASURE;
                    end else begin
                        cntr <= TMO;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef PERIOD_METER_HIGH_TIME_EN
    logic [CNT_W-1:0] hcnt;

    // The rise cycle itself is high, so the count restarts at 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt <= '0;
        end else if (rise) begin
            hcnt <= ONE;
        end else if (level && state != ST_IDLE && hcnt != TMO) begin
            hcnt <= hcnt + ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            high_time <= '0;
        end else if (rise && state == ST_MEASURE) begin
            high_time <= hcnt;
        end
    end
`else
    assign high_time = '0;
`endif

endmodule
